// File: rtl/tick_burst_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_burst_gen_pkg
// Purpose  : Shared types and reset constants for the tick burst generator.
//            Holds the control state encoding and the reset values that the
//            configuration registers and the prescaler fall back to.
// Revision : 1.0 - initial release
// ============================================================================
package tick_burst_gen_pkg;

   // Control state: IDLE accepts configuration and waits for start,
   // RUN produces ticks until stopped or the burst completes.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Reset configuration: divisor 0 and burst 0 means a tick every cycle,
   // continuously, once started.
   localparam int DIV_RST   = 0;
   localparam int BURST_RST = 0;

endpackage : tick_burst_gen_pkg
`default_nettype wire

// File: rtl/tick_burst_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : tick_burst_gen_if
// Purpose  : Bundles the configuration handshake, run control and tick
//            status signals of the tick burst generator.
// Signals  : cfg_valid/cfg_ready/cfg_div/cfg_burst - config handshake
//            start/stop                            - run control (levels)
//            tick/busy/done/ticks_left             - registered status
// Modports : master - the controller driving config and start/stop
//            slave  - the generator itself
// Revision : 1.0 - initial release
// ============================================================================
interface tick_burst_gen_if #(
   parameter int DIV_WIDTH   = 8,
   parameter int BURST_WIDTH = 8
);

   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [DIV_WIDTH-1:0]   cfg_div;
   logic [BURST_WIDTH-1:0] cfg_burst;
   logic                   start;
   logic                   stop;
   logic                   tick;
   logic                   busy;
   logic                   done;
   logic [BURST_WIDTH-1:0] ticks_left;

   modport master (
      output cfg_valid,
      output cfg_div,
      output cfg_burst,
      output start,
      output stop,
      input  cfg_ready,
      input  tick,
      input  busy,
      input  done,
      input  ticks_left
   );

   modport slave (
      input  cfg_valid,
      input  cfg_div,
      input  cfg_burst,
      input  start,
      input  stop,
      output cfg_ready,
      output tick,
      output busy,
      output done,
      output ticks_left
   );

endinterface : tick_burst_gen_if
`default_nettype wire

// File: rtl/tick_burst_gen_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Divide-by-(div+1) down-counter. Fires a strobe on the cycle the
//            count reaches zero and reloads the divisor on that same edge.
// Ports    : clk   - clock
//            clear - synchronous clear of the count (reset or abort)
//            load  - start of a run: take div as the current count
//            run   - keep counting this cycle
//            div   - divisor / reload value
//            fire  - combinational strobe, a tick is due on the next cycle
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler
   import tick_burst_gen_pkg::*;
#(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 load,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 fire
);

   logic [DIV_WIDTH-1:0] pre;
   logic [DIV_WIDTH-1:0] cur;
   logic                 active;

   // The load cycle counts as the first step of the period: the divisor is
   // taken as the current value and decremented on the same edge. That puts
   // the first tick D+1 cycles after the start cycle, and for D=0 it fires
   // straight away so the tick appears in the very first RUN cycle.
   always_comb begin
      active = load || run;
      cur    = load ? div : pre;
      fire   = active && (cur == '0);
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         pre <= DIV_WIDTH'(DIV_RST);
      end else if (active) begin
         pre <= fire ? div : (cur - DIV_WIDTH'(1));
      end
   end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/tick_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_burst_gen
// Purpose  : Programmable enable-strobe generator feeding a counter's enable.
//            Produces a single-cycle tick every (div+1) cycles, either
//            continuously (burst = 0) or for a burst of N ticks, with a done
//            pulse on the final tick. Divisor and burst length are loaded
//            through a valid/ready port that is only open while idle.
// Ports    : clk - clock
//            rst - synchronous active-high reset
//            bus - tick_burst_gen_if.slave (config, start/stop, status)
// Revision : 1.0 - initial release
// ============================================================================
module tick_burst_gen
   import tick_burst_gen_pkg::*;
#(
   parameter int DIV_WIDTH   = 8,
   parameter int BURST_WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   tick_burst_gen_if.slave  bus
);

   // -------------------------------------------------------------------------
   // State and registered outputs
   // -------------------------------------------------------------------------
   state_t                 state;
   state_t                 state_nx;

   logic [DIV_WIDTH-1:0]   div_r;
   logic [BURST_WIDTH-1:0] burst_r;

   logic                   tick_r;
   logic                   busy_r;
   logic                   done_r;
   logic [BURST_WIDTH-1:0] rem_r;

   logic                   tick_nx;
   logic                   busy_nx;
   logic                   done_nx;
   logic [BURST_WIDTH-1:0] rem_nx;

   // -------------------------------------------------------------------------
   // Config handshake and effective run parameters
   // -------------------------------------------------------------------------
   logic                   cfg_ready;
   logic                   cfg_hs;
   logic [DIV_WIDTH-1:0]   eff_div;
   logic [BURST_WIDTH-1:0] eff_burst;
   logic [BURST_WIDTH-1:0] rem_cur;

   logic                   load;
   logic                   run;
   logic                   advance;
   logic                   fire;
   logic                   pre_clear;

   assign cfg_ready = (state == IDLE);
   assign cfg_hs    = bus.cfg_valid && cfg_ready;

   // A handshake coinciding with start must take effect for that very run,
   // so the incoming values bypass the config registers. In RUN no handshake
   // can occur and the stored values are used.
   assign eff_div   = cfg_hs ? bus.cfg_div   : div_r;
   assign eff_burst = cfg_hs ? bus.cfg_burst : burst_r;

   // stop has priority over start in IDLE. In RUN, the cycle that carries
   // the done pulse is the last one: no further counting happens in it.
   assign load      = (state == IDLE) && bus.start && !bus.stop;
   assign run       = (state == RUN)  && !bus.stop && !done_r;
   assign advance   = load || run;
   assign pre_clear = rst || bus.stop;

   // Remaining-tick count that this cycle's decision works from: the new
   // burst length on the start edge, the running count otherwise.
   assign rem_cur   = (state == IDLE) ? eff_burst : rem_r;

   // -------------------------------------------------------------------------
   // Prescaler
   // -------------------------------------------------------------------------
   tick_prescaler #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_prescaler (
      .clk   (clk),
      .clear (pre_clear),
      .load  (load),
      .run   (run),
      .div   (eff_div),
      .fire  (fire)
   );

   // -------------------------------------------------------------------------
   // Next-state and next-output decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      tick_nx  = 1'b0;
      done_nx  = 1'b0;
      rem_nx   = '0;

      unique case (state)
         IDLE: begin
            if (load) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            if (bus.stop || done_r) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      if (advance) begin
         rem_nx = rem_cur;
         if (fire) begin
            tick_nx = 1'b1;
            // A zero remaining count means continuous mode: nothing to count.
            if (rem_cur != '0) begin
               rem_nx  = rem_cur - BURST_WIDTH'(1);
               done_nx = (rem_cur == BURST_WIDTH'(1));
            end
         end
      end

      busy_nx = (state_nx == RUN);
   end

   // -------------------------------------------------------------------------
   // State, output and config registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tick_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         rem_r   <= '0;
         div_r   <= DIV_WIDTH'(DIV_RST);
         burst_r <= BURST_WIDTH'(BURST_RST);
      end else begin
         state   <= state_nx;
         tick_r  <= tick_nx;
         busy_r  <= busy_nx;
         done_r  <= done_nx;
         rem_r   <= rem_nx;
         if (cfg_hs) begin
            div_r   <= bus.cfg_div;
            burst_r <= bus.cfg_burst;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.cfg_ready  = cfg_ready;
   assign bus.tick       = tick_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.ticks_left = rem_r;

endmodule : tick_burst_gen
`default_nettype wire

// File: tb/tb_tick_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_burst_gen
// Purpose  : Self-checking bench for tick_burst_gen. A cycle-level reference
//            model derives tick/done/ticks_left from the cycle index within a
//            run using plain arithmetic (tick when index is a multiple of
//            D+1, ticks so far = index / (D+1)).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_burst_gen;

   localparam int DW = 8;
   localparam int BW = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tick_burst_gen_if #(.DIV_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

   tick_burst_gen #(
      .DIV_WIDTH   (DW),
      .BURST_WIDTH (BW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // {tick, busy, done, cfg_ready, ticks_left}
   logic [11:0] dut_vec;
   assign dut_vec = {bus.tick, bus.busy, bus.done, bus.cfg_ready, bus.ticks_left};

   // -------------------------------------------------------------------------
   // Reference model
   // -------------------------------------------------------------------------
   bit m_run, m_fin;
   int m_j, m_D, m_N, m_div, m_burst;
   bit e_tick, e_busy, e_done;
   int e_left;

   task automatic model_edge();
      int k;
      int d;
      int n;
      e_tick = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_left = 0;
      if (rst) begin
         m_run = 1'b0; m_fin = 1'b0; m_div = 0; m_burst = 0;
         return;
      end
      if (!m_run) begin
         d = m_div;
         n = m_burst;
         if (bus.cfg_valid) begin
            d = int'(bus.cfg_div);
            n = int'(bus.cfg_burst);
            m_div = d;
            m_burst = n;
         end
         if (bus.start && !bus.stop) begin
            m_run = 1'b1; m_D = d; m_N = n; m_j = 0; m_fin = 1'b0;
         end else begin
            return;
         end
      end else if (bus.stop || m_fin) begin
         m_run = 1'b0; m_fin = 1'b0;
         return;
      end
      m_j++;
      e_busy = 1'b1;
      e_tick = ((m_j % (m_D + 1)) == 0);
      if (m_N != 0) begin
         k = m_j / (m_D + 1);
         e_left = m_N - k;
         e_done = e_tick && (k == m_N);
      end
      m_fin = e_done;
   endtask

   function automatic logic [11:0] exp_vec();
      return {e_tick, e_busy, e_done, ~m_run, BW'(e_left)};
   endfunction

   // Advance one clock: update the model from the inputs presented this
   // cycle, then sample the DUT just after the edge.
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_valid = 1'b0;
      bus.cfg_div   = '0;
      bus.cfg_burst = '0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
   endtask

   task automatic load_cfg(input int d, input int n);
      bus.cfg_valid = 1'b1;
      bus.cfg_div   = DW'(d);
      bus.cfg_burst = BW'(n);
      cycle();
      bus.cfg_valid = 1'b0;
   endtask

   // -------------------------------------------------------------------------
   // Tests
   // -------------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if (dut_vec !== 12'b0001_0000_0000) begin
            n_errors++;
            $display("FAIL reset_state cyc %0d: got %h want %h", i, dut_vec, 12'h100);
         end
      end
      rst = 1'b0;
      cycle();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL reset_release: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_default_continuous();
      int ticks = 0;
      int dones = 0;
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL default_cont cyc %0d: got %h want %h", c, dut_vec, exp_vec());
         end
         ticks += int'(bus.tick);
         dones += int'(bus.done);
         if (c < 20) cycle();
      end
      n_checks++;
      if (ticks != 20 || dones != 0) begin
         n_errors++;
         $display("FAIL default_cont_totals: got ticks=%0d dones=%0d want 20/0", ticks, dones);
      end
      bus.stop = 1'b1;
      cycle();
      bus.stop = 1'b0;
   endtask

   task automatic test_burst();
      int ticks = 0;
      int done_cyc = -1;
      int busy_at17 = -1;
      load_cfg(3, 4);
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL burst_d3n4 cyc %0d: got %h want %h", c, dut_vec, exp_vec());
         end
         ticks += int'(bus.tick);
         if (bus.done) done_cyc = c;
         if (c == 17) busy_at17 = int'(bus.busy);
         if (c < 18) cycle();
      end
      n_checks++;
      if (ticks != 4 || done_cyc != 16 || busy_at17 != 0) begin
         n_errors++;
         $display("FAIL burst_d3n4_summary: got ticks=%0d done_cyc=%0d busy17=%0d want 4/16/0",
                  ticks, done_cyc, busy_at17);
      end
   endtask

   task automatic test_cfg_with_start();
      int done_cyc = -1;
      bus.cfg_valid = 1'b1;
      bus.cfg_div   = DW'(1);
      bus.cfg_burst = BW'(2);
      bus.start     = 1'b1;
      cycle();
      idle_inputs();
      for (int c = 1; c <= 6; c++) begin
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL cfg_with_start cyc %0d: got %h want %h", c, dut_vec, exp_vec());
         end
         if (bus.done) done_cyc = c;
         if (c < 6) cycle();
      end
      n_checks++;
      if (done_cyc != 4) begin
         n_errors++;
         $display("FAIL cfg_with_start_done: got cycle %0d want 4", done_cyc);
      end
   endtask

   task automatic test_stop();
      load_cfg(2, 0);
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      cycle();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL stop_pre cyc 2: got %h want %h", dut_vec, exp_vec());
      end
      bus.stop = 1'b1;
      cycle();
      bus.stop = 1'b0;
      n_checks++;
      if (dut_vec !== 12'b0001_0000_0000 || dut_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL stop_abort cyc 3: got %h want %h", dut_vec, 12'h100);
      end
      cycle();
      n_checks++;
      if (bus.tick !== 1'b0 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL stop_stays_idle: got tick=%b busy=%b want 0/0", bus.tick, bus.busy);
      end
   endtask

   task automatic test_start_stop_idle();
      load_cfg(1, 0);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      cycle();
      idle_inputs();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1 || dut_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL start_stop_idle: got %h want %h", dut_vec, exp_vec());
      end
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      // Offer a different divisor while running; it must be refused.
      bus.cfg_valid = 1'b1;
      bus.cfg_div   = DW'(6);
      bus.cfg_burst = BW'(3);
      for (int c = 1; c <= 8; c++) begin
         n_checks++;
         if (bus.cfg_ready !== 1'b0 || dut_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL cfg_in_run cyc %0d: got %h want %h", c, dut_vec, exp_vec());
         end
         cycle();
      end
      idle_inputs();
      bus.stop = 1'b1;
      cycle();
      bus.stop = 1'b0;
      // Restart on stored config: period must still be 2.
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         n_checks++;
         if (bus.tick !== ((c % 2) == 0) || dut_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL div_unchanged cyc %0d: got %h want %h", c, dut_vec, exp_vec());
         end
         cycle();
      end
      bus.stop = 1'b1;
      cycle();
      bus.stop = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      load_cfg(0, 10);
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL mid_burst cyc %0d: got %h want %h", c, dut_vec, exp_vec());
         end
         if (c < 5) cycle();
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      n_checks++;
      if (dut_vec !== 12'b0001_0000_0000) begin
         n_errors++;
         $display("FAIL reset_mid_burst: got %h want %h", dut_vec, 12'h100);
      end
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         n_checks++;
         if (bus.tick !== 1'b1 || bus.ticks_left !== '0 || dut_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL restart_default cyc %0d: got %h want %h", c, dut_vec, exp_vec());
         end
         cycle();
      end
      bus.stop = 1'b1;
      cycle();
      bus.stop = 1'b0;
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      load_cfg(1, 2);
      bus.start = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         cycle();
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL back_to_back cyc %0d: got %h want %h", c, dut_vec, exp_vec());
         end
         dones += int'(bus.done);
      end
      bus.start = 1'b0;
      n_checks++;
      if (dones != 3) begin
         n_errors++;
         $display("FAIL back_to_back_dones: got %0d want 3", dones);
      end
      bus.stop = 1'b1;
      cycle();
      bus.stop = 1'b0;
   endtask

   task automatic test_width_limits();
      int ticks = 0;
      int done_cyc = -1;
      int bad = 0;
      // Maximum divisor: period 256.
      load_cfg(255, 2);
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      for (int c = 1; c <= 514; c++) begin
         if (dut_vec !== exp_vec()) bad++;
         ticks += int'(bus.tick);
         if (bus.done) done_cyc = c;
         if (c < 514) cycle();
      end
      n_checks++;
      if (bad != 0 || ticks != 2 || done_cyc != 512) begin
         n_errors++;
         $display("FAIL max_div: got bad=%0d ticks=%0d done_cyc=%0d want 0/2/512",
                  bad, ticks, done_cyc);
      end
      // Maximum burst: 255 ticks.
      ticks = 0; done_cyc = -1; bad = 0;
      load_cfg(0, 255);
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      n_checks++;
      if (bus.ticks_left !== BW'(254)) begin
         n_errors++;
         $display("FAIL max_burst_first_left: got %0d want 254", bus.ticks_left);
      end
      for (int c = 1; c <= 258; c++) begin
         if (dut_vec !== exp_vec()) bad++;
         ticks += int'(bus.tick);
         if (bus.done) done_cyc = c;
         if (c < 258) cycle();
      end
      n_checks++;
      if (bad != 0 || ticks != 255 || done_cyc != 255) begin
         n_errors++;
         $display("FAIL max_burst: got bad=%0d ticks=%0d done_cyc=%0d want 0/255/255",
                  bad, ticks, done_cyc);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         bus.cfg_valid = ($urandom_range(0, 3) == 0);
         bus.cfg_div   = ($urandom_range(0, 15) == 0) ? DW'($urandom_range(0, 255))
                                                     : DW'($urandom_range(0, 4));
         bus.cfg_burst = ($urandom_range(0, 4) == 0) ? BW'(0) : BW'($urandom_range(1, 6));
         bus.start     = ($urandom_range(0, 2) == 0);
         bus.stop      = ($urandom_range(0, 24) == 0);
         rst           = ($urandom_range(0, 299) == 0);
         cycle();
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL random cyc %0d: got %h want %h", c, dut_vec, exp_vec());
         end
      end
      idle_inputs();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_default_continuous();
      test_burst();
      test_cfg_with_start();
      test_stop();
      test_start_stop_idle();
      test_reset_mid_burst();
      test_back_to_back();
      test_width_limits();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_tick_burst_gen
`default_nettype wire
